hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Reader-side control for the ID/EX register. Consumes the decoded sources in ID plus
//  the ID/EX outputs (mem_read, write_address, RegWrite) and EX branch resolution.
//  Drives stall/flush/hold enables for PC, IF/ID, ID/EX and EX/MEM.
//  Handles load-use bubbles, taken-branch flushes and multi-cycle data-memory waits.
//  Also keeps saturating stall/flush statistics and a sticky memory-timeout flag.
// PARAMETERS
//  CNT_W         16  width of stall_count / flush_count (saturating)
//  FLUSH_CYCLES  1   cycles IF/ID is flushed per taken branch (>=1)
//  MEM_TIMEOUT   15  MEM_WAIT cycles before mem_timeout sets (>=1)
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  reset          in   1      synchronous, active-high
//  id_rs1,id_rs2  in   4      source register addresses of instruction in ID
//  id_uses_rs1/2  in   1      instruction in ID actually reads rs1 / rs2
//  ex_mem_read    in   1      ID/EX mem_read output (load in EX)
//  ex_reg_write   in   1      ID/EX RegWrite output
//  ex_write_addr  in   4      ID/EX write_address output
//  ex_branch_taken in  1      branch resolved taken in EX this cycle
//  mem_req        in   1      MEM stage issuing data-memory access this cycle
//  mem_ready      in   1      data memory completes access this cycle
//  pc_write       out  1      1 = PC may update
//  if_id_write    out  1      1 = IF/ID may load
//  if_id_flush    out  1      1 = IF/ID loads a NOP
//  id_ex_flush    out  1      1 = ID/EX loads all-zero controls (bubble)
//  id_ex_hold     out  1      1 = ID/EX keeps its value
//  ex_mem_hold    out  1      1 = EX/MEM keeps its value
//  stall_count    out  CNT_W  cycles with pc_write==0 (excluding reset)
//  flush_count    out  CNT_W  taken-branch flush events
//  mem_timeout    out  1      sticky: a memory wait reached MEM_TIMEOUT cycles
// BEHAVIOUR
//  Hazard terms (combinational, current cycle):
//   load_use = ex_mem_read & ex_reg_write &
//              ((id_uses_rs1 & id_rs1==ex_write_addr) | (id_uses_rs2 & id_rs2==ex_write_addr))
//   mem_stall = mem_req & ~mem_ready
//  Outputs are combinational from state and inputs. Default: pc_write=if_id_write=1, others 0.
//  Reset asserted: pc_write=if_id_write=0, if_id_flush=id_ex_flush=1, holds=0.
//   Registered reset values: state RUN, counters 0, mem_timeout 0, flush/wait counters 0.
//  FSM states RUN, MEM_WAIT, FLUSH. Priority in every state: mem_stall > branch > load_use.
//  RUN:
//   - mem_stall: freeze (pc_write=if_id_write=0, id_ex_hold=ex_mem_hold=1) -> MEM_WAIT, wait_cnt=1.
//   - else ex_branch_taken: if_id_flush=id_ex_flush=1, pc_write=1; flush_count++.
//     If FLUSH_CYCLES>1 -> FLUSH with fl_cnt=FLUSH_CYCLES-1, else stay RUN.
//   - else load_use: pc_write=if_id_write=0, id_ex_flush=1 (one bubble). Stay RUN.
//     Next cycle the bubble clears ex_mem_read, so the stall is exactly 1 cycle.
//  MEM_WAIT:
//   - mem_ready=0: freeze as above; wait_cnt++ (saturates at MEM_TIMEOUT).
//     When wait_cnt reaches MEM_TIMEOUT, mem_timeout<=1 and stays set until reset.
//     Keeps waiting; never aborts. ex_branch_taken and load_use are ignored while frozen.
//   - mem_ready=1: release; this cycle evaluates branch/load_use exactly as RUN.
//     Next state follows the RUN rules, or RUN; wait_cnt cleared.
//  FLUSH:
//   - if_id_flush=1, pc_write=1, id_ex_flush=0; fl_cnt--; fl_cnt==1 -> RUN.
//   - mem_stall overrides with freeze and -> MEM_WAIT; the remaining flush is abandoned
//     (fetch already redirected).
//   - A new ex_branch_taken in FLUSH is a flushed instruction, so it is ignored.
//  Counters:
//   - stall_count += 1 on every non-reset cycle with pc_write==0.
//   - Both counters saturate at 2^CNT_W-1 with no wrap.
//  Reset mid-wait or mid-flush: next cycle state is RUN and all counters/flags are 0.
// TESTING
//  1. Load r3 in EX, ID reads r3 via rs2 (id_uses_rs2=1): exactly 1 cycle of
//     pc_write=0, id_ex_flush=1; stall_count=1.
//  2. Same but id_uses_rs2=0, or ex_write_addr=4: no stall; all outputs at default.
//  3. ex_branch_taken=1 with FLUSH_CYCLES=1: if_id_flush=id_ex_flush=1 for 1 cycle;
//     flush_count=1. Repeat with FLUSH_CYCLES=3: if_id_flush high 3 cycles.
//  4. mem_req=1, mem_ready low 4 cycles: freeze for 4 cycles, release on the ready cycle;
//     stall_count=4; mem_timeout=0.
//  5. mem_ready low 20 cycles: mem_timeout=1 from wait cycle 15. It stays 1 after release
//     and clears only on reset.
//  6. Load-use and mem_stall together, then reset asserted in MEM_WAIT: freeze wins.
//     After reset: RUN, counters 0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Purpose:
//   Pipeline hazard controller for the ID/EX register. It compares the source
//   registers decoded in ID against the ID/EX outputs and uses EX branch
//   resolution and the data-memory handshake. From these it drives the
//   stall, flush and hold enables for PC, IF/ID, ID/EX and EX/MEM.
//   It handles three cases:
//     - load-use hazards, which insert a one-cycle bubble;
//     - taken branches, which flush IF/ID (and ID/EX) for FLUSH_CYCLES cycles;
//     - multi-cycle data-memory accesses, which freeze the pipe until
//       mem_ready.
//   It also keeps saturating stall/flush statistics and a sticky
//   memory-timeout flag.
//
// Parameters:
//   CNT_W         width of stall_count / flush_count (saturating)
//   FLUSH_CYCLES  cycles IF/ID is flushed per taken branch (>= 1)
//   MEM_TIMEOUT   memory-wait cycles before mem_timeout sets (>= 1)
//
// Ports:
//   clk              in   clock, all state updates on posedge
//   reset            in   synchronous, active-high
//   id_rs1, id_rs2   in   [3:0] source register addresses in ID
//   id_uses_rs1/2    in   ID instruction actually reads rs1 / rs2
//   ex_mem_read      in   load in EX (ID/EX mem_read)
//   ex_reg_write     in   ID/EX RegWrite
//   ex_write_addr    in   [3:0] ID/EX destination register
//   ex_branch_taken  in   branch resolved taken in EX this cycle
//   mem_req          in   MEM stage issues a data-memory access
//   mem_ready        in   data memory completes the access this cycle
//   pc_write         out  PC may update
//   if_id_write      out  IF/ID may load
//   if_id_flush      out  IF/ID loads a NOP
//   id_ex_flush      out  ID/EX loads a bubble (all-zero controls)
//   id_ex_hold       out  ID/EX keeps its value
//   ex_mem_hold      out  EX/MEM keeps its value
//   stall_count      out  [CNT_W-1:0] non-reset cycles with pc_write == 0
//   flush_count      out  [CNT_W-1:0] accepted taken-branch flush events
//   mem_timeout      out  sticky: a memory wait reached MEM_TIMEOUT cycles
//   dbg_state        out  [1:0] current FSM state (0 RUN, 1 MEM_WAIT, 2 FLUSH)
//
// Handshake note:
//   A memory access is outstanding while mem_req is high and mem_ready is low.
//   The access completes in the first cycle in which mem_ready is high.
//   Once the controller is waiting, only mem_ready is looked at.
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [3:0]       ex_write_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [FL_W-1:0]   fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic mem_stall;
    logic freeze;      // whole pipe held for a memory wait
    logic run_eval;    // branch / load-use evaluated this cycle
    logic branch_acc;  // taken branch accepted (counted)

    assign load_use = ex_mem_read & ex_reg_write &
                      ((id_uses_rs1 & (id_rs1 == ex_write_addr)) |
                       (id_uses_rs2 & (id_rs2 == ex_write_addr)));
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        fl_cnt_d      = fl_cnt_q;
        mem_timeout_d = mem_timeout_q;
        freeze        = 1'b0;
        run_eval      = 1'b0;
        branch_acc    = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze = 1'b1;
                    if (wait_cnt_q < WAIT_W'(MEM_TIMEOUT)) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    // Release cycle: behaves exactly like RUN. mem_stall is
                    // necessarily 0 because mem_ready is high.
                    run_eval   = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (mem_stall) begin
                    // Fetch is already redirected, so dropping the remaining
                    // flush cycles is safe.
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    // A branch seen here is itself a flushed instruction: ignored.
                    if_id_flush = 1'b1;
                    fl_cnt_d    = fl_cnt_q - FL_W'(1);
                    if (fl_cnt_q <= FL_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (run_eval) begin
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                branch_acc  = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d  = ST_FLUSH;
                    fl_cnt_d = FL_W'(FLUSH_CYCLES - 1);
                end
            end else if (load_use) begin
                // One bubble is enough: the bubble clears ex_mem_read next cycle.
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        if (freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            // The flag registers at the end of the wait cycle that brings
            // wait_cnt to MEM_TIMEOUT.
            if (wait_cnt_d >= WAIT_W'(MEM_TIMEOUT)) begin
                mem_timeout_d = 1'b1;
            end
        end

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            id_ex_hold  = 1'b0;
            ex_mem_hold = 1'b0;
        end
    end

    // Saturating statistics. Reset cycles are not counted.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!reset && !pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (!reset && branch_acc && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            fl_cnt_q      <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            fl_cnt_q      <= fl_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
    assign mem_timeout = mem_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_controller
//   The bench drives three instances from the same inputs:
//     c : default parameters;
//     f : FLUSH_CYCLES=3, for multi-cycle flush behaviour;
//     s : CNT_W=2 and MEM_TIMEOUT=3, for counter saturation and a short timeout.
//   The stimulus is a linear sequence of directed steps. Each step:
//     1. drives the inputs just after a posedge;
//     2. checks combinational and registered outputs 1 ns later;
//     3. advances to the next posedge.
//   Control outputs are compared as one packed vector:
//     {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold}
// ---------------------------------------------------------------------------
module tb_hazard_stall_controller;

    localparam logic [5:0] K_DEF = 6'b110000;
    localparam logic [5:0] K_RST = 6'b001100;
    localparam logic [5:0] K_FRZ = 6'b000011;
    localparam logic [5:0] K_LU  = 6'b000100;
    localparam logic [5:0] K_BR  = 6'b111100;
    localparam logic [5:0] K_FL  = 6'b111000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] id_rs1, id_rs2, ex_write_addr;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write;
    logic       ex_branch_taken, mem_req, mem_ready;

    logic        c_pcw, c_ifw, c_iff, c_ief, c_ieh, c_emh, c_to;
    logic [15:0] c_stall, c_flush;
    logic [1:0]  c_st;
    logic        f_pcw, f_ifw, f_iff, f_ief, f_ieh, f_emh, f_to;
    logic [15:0] f_stall, f_flush;
    logic [1:0]  f_st;
    logic        s_pcw, s_ifw, s_iff, s_ief, s_ieh, s_emh, s_to;
    logic [1:0]  s_stall, s_flush;
    logic [1:0]  s_st;

    logic [5:0] c_ctl, f_ctl, s_ctl;
    assign c_ctl = {c_pcw, c_ifw, c_iff, c_ief, c_ieh, c_emh};
    assign f_ctl = {f_pcw, f_ifw, f_iff, f_ief, f_ieh, f_emh};
    assign s_ctl = {s_pcw, s_ifw, s_iff, s_ief, s_ieh, s_emh};

    int checks   = 0;
    int failures = 0;

    // clock
    always #5 clk = ~clk;

    hazard_stall_controller dut_c (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_write_addr(ex_write_addr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(c_pcw), .if_id_write(c_ifw), .if_id_flush(c_iff),
        .id_ex_flush(c_ief), .id_ex_hold(c_ieh), .ex_mem_hold(c_emh),
        .stall_count(c_stall), .flush_count(c_flush), .mem_timeout(c_to),
        .dbg_state(c_st)
    );

    hazard_stall_controller #(.FLUSH_CYCLES(3)) dut_f (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_write_addr(ex_write_addr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(f_pcw), .if_id_write(f_ifw), .if_id_flush(f_iff),
        .id_ex_flush(f_ief), .id_ex_hold(f_ieh), .ex_mem_hold(f_emh),
        .stall_count(f_stall), .flush_count(f_flush), .mem_timeout(f_to),
        .dbg_state(f_st)
    );

    hazard_stall_controller #(.CNT_W(2), .MEM_TIMEOUT(3)) dut_s (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_write_addr(ex_write_addr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pcw), .if_id_write(s_ifw), .if_id_flush(s_iff),
        .id_ex_flush(s_ief), .id_ex_hold(s_ieh), .ex_mem_hold(s_emh),
        .stall_count(s_stall), .flush_count(s_flush), .mem_timeout(s_to),
        .dbg_state(s_st)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_addr = 4'd0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] wa);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_addr = wa;
    endtask

    initial begin
        // reset
        idle(); reset = 1'b1;
        tick(); tick();
        #1;
        check("rst_ctl_c", c_ctl, K_RST);
        check("rst_ctl_f", f_ctl, K_RST);
        check("rst_stall_c", c_stall, 0);
        check("rst_flush_c", c_flush, 0);
        check("rst_to_c", c_to, 0);
        check("rst_state_c", c_st, 0);
        reset = 1'b0; #1;
        check("run_default_c", c_ctl, K_DEF);
        tick();

        // load-use via rs2: one bubble
        set_load(4'd3); id_rs2 = 4'd3; id_uses_rs2 = 1'b1; id_rs1 = 4'd5; id_uses_rs1 = 1'b1; #1;
        check("lu_rs2_ctl", c_ctl, K_LU);
        tick();
        idle(); #1;
        check("lu_after_ctl", c_ctl, K_DEF);
        check("lu_stall_c", c_stall, 1);
        tick();

        // near misses: no stall
        set_load(4'd3); id_rs2 = 4'd3; id_uses_rs2 = 1'b0; id_rs1 = 4'd5; id_uses_rs1 = 1'b1; #1;
        check("nolu_unused_rs2", c_ctl, K_DEF);
        tick();
        set_load(4'd4); id_rs2 = 4'd3; id_uses_rs2 = 1'b1; #1;
        check("nolu_addr4", c_ctl, K_DEF);
        tick();
        set_load(4'd3); ex_reg_write = 1'b0; #1;
        check("nolu_no_regwrite", c_ctl, K_DEF);
        tick();

        // load-use via rs1
        idle(); set_load(4'd7); id_rs1 = 4'd7; id_uses_rs1 = 1'b1; #1;
        check("lu_rs1_ctl", c_ctl, K_LU);
        tick();

        // taken branch (with a coincident load-use: branch wins)
        idle(); set_load(4'd2); id_rs1 = 4'd2; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1; #1;
        check("br_ctl_c", c_ctl, K_BR);
        check("br_ctl_f", f_ctl, K_BR);
        check("br_stall_c", c_stall, 2);
        tick();
        idle(); ex_branch_taken = 1'b1; #1;
        check("br2_ctl_c", c_ctl, K_BR);
        check("fl1_ctl_f", f_ctl, K_FL);
        check("fl1_state_f", f_st, 2);
        check("br_flush_c", c_flush, 1);
        check("br_flush_f", f_flush, 1);
        tick();
        idle(); #1;
        check("fl2_ctl_f", f_ctl, K_FL);
        check("br_done_ctl_c", c_ctl, K_DEF);
        check("br2_flush_c", c_flush, 2);
        check("fl_ignored_flush_f", f_flush, 1);
        tick();
        idle(); #1;
        check("fl_end_ctl_f", f_ctl, K_DEF);
        check("fl_end_state_f", f_st, 0);
        tick();

        // 4-cycle memory wait, release with a taken branch
        for (int k = 1; k <= 4; k++) begin
            idle(); mem_req = 1'b1; #1;
            check($sformatf("mw4_ctl_c_%0d", k), c_ctl, K_FRZ);
            check($sformatf("mw4_ctl_s_%0d", k), s_ctl, K_FRZ);
            if (k == 3) check("mw4_to_s_before", s_to, 0);
            if (k == 4) check("mw4_to_s_set", s_to, 1);
            tick();
        end
        mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1; #1;
        check("mw4_release_br_c", c_ctl, K_BR);
        tick();
        idle(); #1;
        check("mw4_stall_c", c_stall, 6);
        check("mw4_stall_sat_s", s_stall, 3);
        check("mw4_to_c", c_to, 0);
        check("mw4_to_sticky_s", s_to, 1);
        check("mw4_flush_c", c_flush, 3);
        check("mw4_flush_s", s_flush, 3);
        check("mw4_state_c", c_st, 0);
        check("mw4_state_f", f_st, 2);
        tick();
        idle(); #1;
        tick();

        // branch, then mem stall during FLUSH abandons the flush
        idle(); ex_branch_taken = 1'b1; #1;
        check("brx_ctl_f", f_ctl, K_BR);
        tick();
        idle(); mem_req = 1'b1; #1;
        check("fl_memstall_ctl_f", f_ctl, K_FRZ);
        check("fl_memstall_state_f", f_st, 2);
        check("brx_flush_c", c_flush, 4);
        check("brx_flush_sat_s", s_flush, 3);
        tick();
        idle(); mem_req = 1'b1; mem_ready = 1'b1; #1;
        check("fl_mw_release_ctl_f", f_ctl, K_DEF);
        check("fl_mw_state_f", f_st, 1);
        tick();
        idle(); #1;
        check("fl_abandon_state_f", f_st, 0);
        check("brx_stall_c", c_stall, 7);
        tick();

        // 20-cycle memory wait: timeout at wait cycle 15, sticky after
        for (int k = 1; k <= 20; k++) begin
            idle(); mem_req = 1'b1;
            if (k == 10) begin
                ex_branch_taken = 1'b1; set_load(4'd1); id_rs1 = 4'd1; id_uses_rs1 = 1'b1;
            end
            #1;
            check($sformatf("mw20_ctl_c_%0d", k), c_ctl, K_FRZ);
            if (k == 15) check("mw20_to_before", c_to, 0);
            if (k == 16) check("mw20_to_set", c_to, 1);
            tick();
        end
        mem_req = 1'b1; mem_ready = 1'b1; #1;
        check("mw20_release_c", c_ctl, K_DEF);
        tick();
        idle(); #1;
        check("mw20_to_sticky1", c_to, 1);
        check("mw20_stall_c", c_stall, 27);
        check("mw20_flush_c", c_flush, 4);
        tick();
        idle(); #1;
        check("mw20_to_sticky2", c_to, 1);
        tick();

        // load-use + mem stall: freeze wins, then reset inside MEM_WAIT
        idle(); set_load(4'd5); id_rs2 = 4'd5; id_uses_rs2 = 1'b1; mem_req = 1'b1; #1;
        check("lu_mw_freeze_c", c_ctl, K_FRZ);
        tick();
        #1;
        check("lu_mw_hold_c", c_ctl, K_FRZ);
        check("lu_mw_state_c", c_st, 1);
        reset = 1'b1; #1;
        check("mid_rst_ctl_c", c_ctl, K_RST);
        tick();
        reset = 1'b0; idle(); #1;
        check("post_rst_ctl_c", c_ctl, K_DEF);
        check("post_rst_state_c", c_st, 0);
        check("post_rst_stall_c", c_stall, 0);
        check("post_rst_flush_c", c_flush, 0);
        check("post_rst_to_c", c_to, 0);
        check("post_rst_to_s", s_to, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
